alu8_seq: RTL and testbench

Nibble-serial 8-bit ALU sequencer for the 6502 datapath. It time-multiplexes a single `alu4` slice across the low and high nibbles of an 8-bit operation and chains the carry through a register. For decimal-mode ADD it adds two BCD-correction passes. It presents a start/done handshake to the CPU control unit and produces the result plus C/Z/N/V flags.

---
 rtl/alu8_seq_pkg.sv | 22 ++
 rtl/alu8_seq_alu4.sv | 29 ++
 rtl/alu8_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu8_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu8_seq_pkg.sv
// rtl/alu8_seq_pkg.sv - shared opcodes, BCD constant and FSM states for alu8_seq
package alu8_seq_pkg;

    localparam logic [3:0] ALU_S_ADD = 4'b1001;
    localparam logic [3:0] ALU_S_SUB = 4'b0110;
    localparam logic [3:0] BCD_FIX   = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LO     = 3'd1,
        ST_HI     = 3'd2,
        ST_ADJ_LO = 3'd3,
        ST_ADJ_HI = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Signed overflow of a + beff + ci, judged from the sign bits only.
    function automatic logic add_ovf(input logic a7, input logic beff7, input logic f7);
        return (a7 ~^ beff7) & (a7 ^ f7);
    endfunction

endpackage

// File: rtl/alu8_seq_alu4.sv
// rtl/alu8_seq_alu4.sv - 4-bit 74181-style ALU slice, active-high data
module alu8_seq_alu4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic [3:0] s,
    input  logic       m,
    output logic [3:0] f,
    output logic       co
);
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;

    // Arithmetic is x plus y plus ci; logic mode is the carry-free XNOR of the same terms.
    always_comb begin
        x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        if (m) begin
            f  = sum[3:0];
            co = sum[4];
        end else begin
            f  = ~(x ^ y);
            co = 1'b0;
        end
    end

endmodule

// File: rtl/alu8_seq.sv
// rtl/alu8_seq.sv - nibble-serial 8-bit ALU sequencer with decimal ADD correction
module alu8_seq
    import alu8_seq_pkg::*;
#(
    parameter bit DEC_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       dec,
    output logic       busy,
    output logic       done,
    output logic [7:0] f,
    output logic       co,
    output logic       z,
    output logic       n,
    output logic       v
);
    state_e     state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic [3:0] s_q, s_d;
    logic       ci_q, ci_d, m_q, m_d, dec_q, dec_d;
    logic [3:0] lo_q, lo_d, hi_q, hi_d;
    logic       c_lo_q, c_lo_d, co_bin_q, co_bin_d, c1_q, c1_d;
    logic [7:0] f_q, f_d;
    logic       co_q, co_d, z_q, z_d, n_q, n_d, v_q, v_d;
    logic [3:0] alu_a, alu_b, alu_s, alu_f;
    logic       alu_ci, alu_m, alu_co;
    logic       lo_fix, hi_fix, beff7;

    alu8_seq_alu4 u_alu4 (
        .a  (alu_a),
        .b  (alu_b),
        .ci (alu_ci),
        .s  (alu_s),
        .m  (alu_m),
        .f  (alu_f),
        .co (alu_co)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            s_q      <= 4'h0;
            ci_q     <= 1'b0;
            m_q      <= 1'b0;
            dec_q    <= 1'b0;
            lo_q     <= 4'h0;
            hi_q     <= 4'h0;
            c_lo_q   <= 1'b0;
            co_bin_q <= 1'b0;
            c1_q     <= 1'b0;
            f_q      <= 8'h00;
            co_q     <= 1'b0;
            z_q      <= 1'b1;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            ci_q     <= ci_d;
            m_q      <= m_d;
            dec_q    <= dec_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            c_lo_q   <= c_lo_d;
            co_bin_q <= co_bin_d;
            c1_q     <= c1_d;
            f_q      <= f_d;
            co_q     <= co_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        ci_d     = ci_q;
        m_d      = m_q;
        dec_d    = dec_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        c_lo_d   = c_lo_q;
        co_bin_d = co_bin_q;
        c1_d     = c1_q;
        f_d      = f_q;
        co_d     = co_q;
        v_d      = v_q;
        alu_a    = 4'h0;
        alu_b    = 4'h0;
        alu_ci   = 1'b0;
        alu_s    = s_q;
        alu_m    = m_q;
        lo_fix   = (lo_q > 4'd9) | c_lo_q;
        hi_fix   = co_bin_q | (hi_q > 4'd9) | ((hi_q == 4'd9) & c1_q);
        beff7    = (s_q == ALU_S_SUB) ? ~b_q[7] : b_q[7];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = s;
                    ci_d    = ci;
                    m_d     = m;
                    dec_d   = DEC_EN & dec & m & (s == ALU_S_ADD);
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                alu_a   = a_q[3:0];
                alu_b   = b_q[3:0];
                alu_ci  = ci_q;
                lo_d    = alu_f;
                c_lo_d  = alu_co;
                state_d = ST_HI;
            end
            ST_HI: begin
                alu_a    = a_q[7:4];
                alu_b    = b_q[7:4];
                alu_ci   = c_lo_q;
                hi_d     = alu_f;
                co_bin_d = alu_co;
                v_d      = m_q & ((s_q == ALU_S_ADD) | (s_q == ALU_S_SUB))
                           & add_ovf(a_q[7], beff7, alu_f[3]);
                if (dec_q) begin
                    state_d = ST_ADJ_LO;
                end else begin
                    f_d     = {alu_f, lo_q};
                    co_d    = alu_co;
                    state_d = ST_DONE;
                end
            end
            ST_ADJ_LO: begin
                alu_a   = lo_q;
                alu_b   = lo_fix ? BCD_FIX : 4'h0;
                alu_s   = ALU_S_ADD;
                alu_m   = 1'b1;
                lo_d    = alu_f;
                c1_d    = alu_co;
                state_d = ST_ADJ_HI;
            end
            ST_ADJ_HI: begin
                alu_a   = hi_q;
                alu_b   = hi_fix ? BCD_FIX : 4'h0;
                alu_ci  = c1_q;
                alu_s   = ALU_S_ADD;
                alu_m   = 1'b1;
                hi_d    = alu_f;
                f_d     = {alu_f, lo_q};
                co_d    = co_bin_q | hi_fix;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Flags follow the result register, so they stay coherent while it holds.
        z_d = (f_d == 8'h00);
        n_d = f_d[7];
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign f    = f_q;
    assign co   = co_q;
    assign z    = z_q;
    assign n    = n_q;
    assign v    = v_q;

endmodule

// File: tb/tb_alu8_seq.sv
// tb/tb_alu8_seq.sv - self-checking bench for alu8_seq
module tb_alu8_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a, b;
    logic       ci, m, dec;
    logic [3:0] s;
    logic       busy, done, co, z, n, v;
    logic [7:0] f;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic       op_active = 1'b0;
    int         acc_cyc = 0;
    int         lat = 3;
    int         last_done_cyc = -1;
    logic [7:0] m_f = 8'h00;
    logic       m_co = 1'b0;
    logic       m_v = 1'b0;
    logic [7:0] held_f = 8'h00;
    logic       held_co = 1'b0;
    logic       held_v = 1'b0;

    alu8_seq #(.DEC_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .s     (s),
        .m     (m),
        .dec   (dec),
        .busy  (busy),
        .done  (done),
        .f     (f),
        .co    (co),
        .z     (z),
        .n     (n),
        .v     (v)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] logic_fn(input logic [3:0] fs, input logic [7:0] x, input logic [7:0] y);
        case (fs)
            4'h0: return ~x;
            4'h1: return ~(x | y);
            4'h2: return ~x & y;
            4'h3: return 8'h00;
            4'h4: return ~(x & y);
            4'h5: return ~y;
            4'h6: return x ^ y;
            4'h7: return x & ~y;
            4'h8: return ~x | y;
            4'h9: return ~(x ^ y);
            4'hA: return y;
            4'hB: return x & y;
            4'hC: return 8'hFF;
            4'hD: return x | ~y;
            4'hE: return x | y;
            default: return x;
        endcase
    endfunction

    function automatic int bcd_val(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    task automatic model_op(input logic [7:0] ia, input logic [7:0] ib, input logic ici,
                            input logic [3:0] is, input logic im, input logic idec);
        int sa, sb, sum, sv, d;
        sa = (ia > 8'd127) ? int'(ia) - 256 : int'(ia);
        sb = (ib > 8'd127) ? int'(ib) - 256 : int'(ib);
        m_v = 1'b0;
        lat = 3;
        if (!im) begin
            m_f  = logic_fn(is, ia, ib);
            m_co = 1'b0;
        end else if (is == 4'b1001) begin
            sum  = int'(ia) + int'(ib) + int'(ici);
            m_f  = sum[7:0];
            m_co = (sum > 255);
            sv   = sa + sb + int'(ici);
            m_v  = (sv > 127) || (sv < -128);
            if (idec) begin
                d    = bcd_val(ia) + bcd_val(ib) + int'(ici);
                m_co = (d >= 100);
                d    = d % 100;
                sum  = (d / 10) * 16 + (d % 10);
                m_f  = sum[7:0];
                lat  = 5;
            end
        end else begin
            sum  = int'(ia) + (255 - int'(ib)) + int'(ici);
            m_f  = sum[7:0];
            m_co = (sum > 255);
            sv   = sa - sb - 1 + int'(ici);
            m_v  = (sv > 127) || (sv < -128);
        end
    endtask

    always @(negedge clk) begin
        logic exp_busy, exp_done;
        exp_busy = op_active && (cyc >= acc_cyc) && (cyc < acc_cyc + lat);
        exp_done = op_active && (cyc == acc_cyc + lat - 1);
        if (done) last_done_cyc = cyc;
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        if (exp_done) begin
            held_f  = m_f;
            held_co = m_co;
            held_v  = m_v;
        end
        if (exp_done || !exp_busy) begin
            chk("f", f, held_f);
            chk("co", co, held_co);
            chk("z", z, held_f == 8'h00);
            chk("n", n, held_f[7]);
            chk("v", v, held_v);
        end
    end

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ici,
                         input logic [3:0] is, input logic im, input logic idec, input bit hold);
        a = ia; b = ib; ci = ici; s = is; m = im; dec = idec;
        start = 1'b1;
        model_op(ia, ib, ici, is, im, idec);
        acc_cyc = cyc + 1;
        op_active = 1'b1;
        last_done_cyc = -1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string nm, input logic [7:0] ef, input logic ec, input logic ez,
                              input logic en, input logic ev, input int done_off);
        chk({nm, "_f"}, f, ef);
        chk({nm, "_co"}, co, ec);
        chk({nm, "_z"}, z, ez);
        chk({nm, "_n"}, n, en);
        chk({nm, "_v"}, v, ev);
        chk({nm, "_lat"}, last_done_cyc - acc_cyc, done_off);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        a = 8'h00; b = 8'h00; ci = 1'b0; s = 4'h0; m = 1'b0; dec = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_f", f, 8'h00);
        chk("rst_z", z, 1'b1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        issue(8'h3A, 8'h47, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0);
        expect_res("add", 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        issue(8'h50, 8'h10, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
        expect_res("sub1", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        issue(8'h80, 8'h01, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
        expect_res("sub2", 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        issue(8'hFF, 8'h01, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0);
        expect_res("addc", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        repeat (2) @(posedge clk);
        #1;

        issue(8'h19, 8'h28, 1'b0, 4'b1001, 1'b1, 1'b1, 1'b0);
        expect_res("dec1", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        issue(8'h99, 8'h01, 1'b0, 4'b1001, 1'b1, 1'b1, 1'b0);
        expect_res("dec2", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4);
        issue(8'h45, 8'h54, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b0);
        expect_res("dec3", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4);
        issue(8'h50, 8'h10, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
        expect_res("subdec", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 2);

        issue(8'h5A, 8'h0F, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b0);
        expect_res("logxn", 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        issue(8'hF0, 8'h3C, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        expect_res("logand", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        issue(8'hA0, 8'h05, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
        expect_res("logor", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        repeat (3) @(posedge clk);
        #1;

        issue(8'h12, 8'h34, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b1);
        expect_res("hold1", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        chk("hold_start", start, 1'b1);
        issue(8'h0F, 8'h01, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0);
        expect_res("hold2", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_keep", f, 8'h10);

        a = 8'h3A; b = 8'h47; ci = 1'b0; s = 4'b1001; m = 1'b1; dec = 1'b0;
        start = 1'b1;
        model_op(a, b, ci, s, m, dec);
        acc_cyc = cyc + 1;
        op_active = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        op_active = 1'b0;
        held_f = 8'h00; held_co = 1'b0; held_v = 1'b0;
        #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_f", f, 8'h00);
        chk("mid_z", z, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_done", done, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        issue(8'h22, 8'h11, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0);
        expect_res("after_rst", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
